// File: rtl/alu_cmd_sequencer_if.sv
// Command, ALU-issue and response signal bundle for alu_cmd_sequencer.
// slave = sequencer side, master = host/ALU side.
interface alu_cmd_sequencer_if #(
    parameter int DEPTH = 4
);
    logic                     cmd_valid;
    logic                     cmd_ready;
    logic [3:0]               cmd_op;
    logic [7:0]               cmd_a;
    logic [7:0]               cmd_b;
    logic                     cmd_use_acc;
    logic [3:0]               alu_opcode;
    logic [7:0]               alu_a;
    logic [7:0]               alu_b;
    logic [15:0]              alu_result;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [3:0]               rsp_op;
    logic [15:0]              rsp_result;
    logic                     busy;
    logic [$clog2(DEPTH):0]   count;

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_use_acc, alu_result, rsp_ready,
        input  cmd_ready, alu_opcode, alu_a, alu_b, rsp_valid, rsp_op, rsp_result, busy, count
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_use_acc, alu_result, rsp_ready,
        output cmd_ready, alu_opcode, alu_a, alu_b, rsp_valid, rsp_op, rsp_result, busy, count
    );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Buffered issue stage for the 8-bit ALU: FIFO of commands, IDLE/EXEC/HOLD issue FSM, result return.
// Optional macro ALU_SEQ_DROP_NOP_EN discards NOP commands in IDLE instead of issuing them.
module alu_cmd_sequencer #(
    parameter int DEPTH = 4
) (
    input logic                clk,
    input logic                rst,
    alu_cmd_sequencer_if.slave bus
);
    localparam int            AW     = $clog2(DEPTH);
    localparam logic [AW:0]   FULL   = (AW+1)'(DEPTH);
    localparam logic [3:0]    OP_NOP = 4'd0;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;

    // entry layout: {use_acc, op, a, b}
    logic [20:0]    mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW:0]    count;
    logic [1:0]     state;
    logic [7:0]     acc;

    logic [3:0]     alu_opcode;
    logic [7:0]     alu_a;
    logic [7:0]     alu_b;
    logic           rsp_valid;
    logic [3:0]     rsp_op;
    logic [15:0]    rsp_result;

    logic           head_use_acc;
    logic [3:0]     head_op;
    logic [7:0]     head_a;
    logic [7:0]     head_b;
    logic           push;
    logic           pop;
    logic           issue;

    assign {head_use_acc, head_op, head_a, head_b} = mem[rd_ptr];

    assign bus.cmd_ready = (count != FULL);
    assign push          = bus.cmd_valid && bus.cmd_ready;
    assign pop           = (state == IDLE) && (count != '0);

    always_comb begin
        issue = pop;
`ifdef ALU_SEQ_DROP_NOP_EN
        issue = pop && (head_op != OP_NOP);
`endif
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {bus.cmd_use_acc, bus.cmd_op, bus.cmd_a, bus.cmd_b};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            state      <= IDLE;
            acc        <= '0;
            alu_opcode <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            rsp_valid  <= 1'b0;
            rsp_op     <= '0;
            rsp_result <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase

            case (state)
                IDLE: begin
                    // a dropped NOP still pops, so the next entry is visible next cycle
                    if (issue) begin
                        alu_opcode <= head_op;
                        alu_a      <= head_use_acc ? acc : head_a;
                        alu_b      <= head_b;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_op     <= alu_opcode;
                    rsp_valid  <= 1'b1;
                    if (alu_opcode == OP_NOP) begin
                        rsp_result <= '0;
                    end else begin
                        rsp_result <= bus.alu_result;
                        acc        <= bus.alu_result[7:0];
                    end
                    state <= HOLD;
                end
                HOLD: begin
                    if (bus.rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.alu_opcode = alu_opcode;
    assign bus.alu_a      = alu_a;
    assign bus.alu_b      = alu_b;
    assign bus.rsp_valid  = rsp_valid;
    assign bus.rsp_op     = rsp_op;
    assign bus.rsp_result = rsp_result;
    assign bus.count      = count;
    assign bus.busy       = (state != IDLE) || (count != '0);
endmodule
